// File: rtl/patp_memory_store.sv
// patp_memory_store: main store for the PATP core.
// After reset the store zeroes itself (CLEAR), then accepts a program image
// over the load port (LOAD). Only after that does it release the core (RUN)
// and answer the sequencer's we_mar/read/oe_ms/write strobes against its MAR.
//
// Load port handshake: a word transfers on every rising edge where
// prog_ready and prog_valid are both high. prog_ready is high only in LOAD.
// The source may hold prog_valid across cycles; each such edge is a new write.
//
// Optional feature: define PATP_MS_COLLISION_CHECK_EN to add the sticky
// coll_err output, which flags read/oe_ms overlapping a write while in RUN.
module patp_memory_store #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              we_mar,
  input  logic              read,
  input  logic              oe_ms,
  input  logic              write,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  output logic              core_hold,
  output logic [ADDR_W-1:0] mar,
`ifdef PATP_MS_COLLISION_CHECK_EN
  output logic              coll_err,
`endif
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // One bit wider than the address so the terminal count is unambiguous.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] CLR_ONE  = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W:0]     clr_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  assign fsm_state = state;

  // Sequencer: CLEAR walks every address, LOAD waits for prog_done, RUN owns the MAR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_ptr    <= '0;
      mar        <= '0;
      prog_ready <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + CLR_ONE;
          if (clr_ptr == CLR_LAST) begin
            state      <= ST_LOAD;
            prog_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (prog_done) begin
            state      <= ST_RUN;
            prog_ready <= 1'b0;
            core_hold  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (we_mar) mar <= bus_in[ADDR_W-1:0];
        end
        default: begin
          state      <= ST_CLEAR;
          clr_ptr    <= '0;
          prog_ready <= 1'b0;
          core_hold  <= 1'b1;
        end
      endcase
    end
  end

  // Single write port: the current state picks who owns it.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (rst_n) begin
      case (state)
        ST_CLEAR: begin
          mem_we = 1'b1;
          mem_wa = clr_ptr[ADDR_W-1:0];
          mem_wd = '0;
        end
        ST_LOAD: begin
          mem_we = prog_valid;
          mem_wa = prog_addr;
          mem_wd = prog_data;
        end
        ST_RUN: begin
          // Uses the MAR value from before any same-cycle we_mar.
          mem_we = write;
          mem_wa = mar;
          mem_wd = bus_in;
        end
        default: begin
          mem_we = 1'b0;
        end
      endcase
    end
  end

  // Storage array; contents are only ever initialised by the CLEAR walk.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Zero-latency read so the IR or D0 can latch in the same T-state;
  // a same-cycle write shows the old data here and commits at the edge.
  assign bus_oe  = (state == ST_RUN) && read && oe_ms;
  assign bus_out = bus_oe ? mem[mar] : '0;

`ifdef PATP_MS_COLLISION_CHECK_EN
  logic coll_err_q;

  // Sticky flag for a write overlapping read or oe_ms in RUN; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_err_q <= 1'b0;
    end else if ((state == ST_RUN) && write && (read || oe_ms)) begin
      coll_err_q <= 1'b1;
    end
  end

  assign coll_err = coll_err_q;
`endif

endmodule

// File: tb/tb_patp_memory_store.sv
// Testbench for patp_memory_store: reset/CLEAR timing, LOAD, a full RUN
// read sweep, a table of RUN strobe vectors and a mid-RUN reset.
module tb_patp_memory_store;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] bus_in;
  logic              we_mar, read, oe_ms, write;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              prog_valid, prog_ready, prog_done;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              core_hold;
  logic [ADDR_W-1:0] mar;
  logic [1:0]        fsm_state;
`ifdef PATP_MS_COLLISION_CHECK_EN
  logic              coll_err;
`endif

  patp_memory_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_in     (bus_in),
    .we_mar     (we_mar),
    .read       (read),
    .oe_ms      (oe_ms),
    .write      (write),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_done  (prog_done),
    .core_hold  (core_hold),
    .mar        (mar),
`ifdef PATP_MS_COLLISION_CHECK_EN
    .coll_err   (coll_err),
`endif
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic              we_mar;
    logic              read;
    logic              oe_ms;
    logic              write;
    logic [DATA_W-1:0] bus_in;
    logic              exp_oe;
    logic [DATA_W-1:0] exp_out;
    logic [ADDR_W-1:0] exp_mar;
  } vec_t;

  localparam int EW = 1 + ADDR_W + DATA_W;
  logic [EW-1:0]     exp_q[$];
  vec_t              vecs[14];
  logic [DATA_W-1:0] img[DEPTH];
  logic [ADDR_W-1:0] cur_mar;
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wm, input logic rd, input logic oe,
                       input logic wr, input logic [DATA_W-1:0] b);
    we_mar = wm;
    read   = rd;
    oe_ms  = oe;
    write  = wr;
    bus_in = b;
  endtask

  task automatic push_exp(input logic oe, input logic [ADDR_W-1:0] m,
                          input logic [DATA_W-1:0] d);
    exp_q.push_back({oe, m, d});
  endtask

  // Compare the queued expectation mid-cycle, then advance past the next edge.
  task automatic sb_cycle(input string name);
    logic [EW-1:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_oe"},  {31'd0, bus_oe}, {31'd0, e[EW-1]});
      check({name, "_mar"}, {27'd0, mar},    {27'd0, e[EW-2 -: ADDR_W]});
      check({name, "_out"}, {24'd0, bus_out}, {24'd0, e[DATA_W-1:0]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_addr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d);
    drive(1'b1, 1'b0, 1'b0, 1'b0, {3'b000, a});
    push_exp(1'b0, cur_mar, 8'h00);
    sb_cycle($sformatf("mar_ld_%0d", a));
    cur_mar = a;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    push_exp(1'b1, a, exp_d);
    sb_cycle($sformatf("rd_%0d", a));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic prog_word(input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic done);
    check("prog_ready_load", {31'd0, prog_ready}, 32'd1);
    prog_valid = v;
    prog_addr  = a;
    prog_data  = d;
    prog_done  = done;
    @(posedge clk);
    #1;
    prog_valid = 1'b0;
    prog_done  = 1'b0;
  endtask

  // Count edges until prog_ready rises; bounded so a stuck DUT still reports.
  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (prog_ready !== 1'b1 && cnt < 40) begin
      check({name, "_hold"}, {31'd0, core_hold}, 32'd1);
      @(posedge clk);
      #1;
      cnt++;
    end
    check({name, "_cycles"}, cnt, 32'd32);
    check({name, "_ready"}, {31'd0, prog_ready}, 32'd1);
    check({name, "_state"}, {30'd0, fsm_state}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    prog_valid = 1'b0;
    prog_addr  = '0;
    prog_data  = '0;
    prog_done  = 1'b0;
    // Core strobes active through CLEAR and LOAD: all must be ignored.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h1F);

    // RUN vector table: {we_mar, read, oe_ms, write, bus_in, exp_oe, exp_out, exp_mar}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 8'h00, 5'h1F};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 5'h1F};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 5'h1F};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'h1F};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'h1F};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 5'h1F};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 5'h01};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 5'h02};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 5'h02};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 8'h02, 5'h01};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3, 5'h01};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hE3, 1'b0, 8'h00, 5'h01};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h5C, 5'h03};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'h03};

    for (int i = 0; i < DEPTH; i++) img[i] = 8'h00;
    img[3] = 8'h5C;
    img[7] = 8'h3C;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_core_hold",  {31'd0, core_hold},  32'd1);
    check("rst_prog_ready", {31'd0, prog_ready}, 32'd0);
    check("rst_bus_oe",     {31'd0, bus_oe},     32'd0);
    check("rst_bus_out",    {24'd0, bus_out},    32'd0);
    check("rst_mar",        {27'd0, mar},        32'd0);
    check("rst_state",      {30'd0, fsm_state},  32'd0);
    rst_n = 1'b1;
    wait_clear("clear1");
    check("load_bus_oe", {31'd0, bus_oe}, 32'd0);
    check("load_mar",    {27'd0, mar},    32'd0);
`ifdef PATP_MS_COLLISION_CHECK_EN
    check("load_coll_err", {31'd0, coll_err}, 32'd0);
`endif

    // LOAD: repeated address (last wins) and a write on the prog_done cycle
    prog_word(1'b1, 5'd3, 8'hA5, 1'b0);
    prog_word(1'b1, 5'd3, 8'h5C, 1'b0);
    prog_word(1'b1, 5'd7, 8'h3C, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("run_core_hold",  {31'd0, core_hold},  32'd0);
    check("run_prog_ready", {31'd0, prog_ready}, 32'd0);
    check("run_state",      {30'd0, fsm_state},  32'd2);
`ifdef PATP_MS_COLLISION_CHECK_EN
    check("load_end_coll_err", {31'd0, coll_err}, 32'd0);
`endif

    // Load port ignored in RUN
    prog_valid = 1'b1;
    prog_addr  = 5'd5;
    prog_data  = 8'hEE;
    prog_done  = 1'b1;
    @(posedge clk);
    #1;
    prog_valid = 1'b0;
    prog_done  = 1'b0;
    check("run_ready_ignored", {31'd0, prog_ready}, 32'd0);

    // Full read sweep against the expected image
    cur_mar = 5'd0;
    for (int a = 0; a < DEPTH; a++) read_addr(5'(a), img[a]);

    // RUN strobe table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we_mar, vecs[i].read, vecs[i].oe_ms, vecs[i].write, vecs[i].bus_in);
      push_exp(vecs[i].exp_oe, vecs[i].exp_mar, vecs[i].exp_out);
      sb_cycle($sformatf("vec%0d", i));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cur_mar = 5'h03;
`ifdef PATP_MS_COLLISION_CHECK_EN
    check("coll_err_set", {31'd0, coll_err}, 32'd1);
    @(posedge clk);
    #1;
    check("coll_err_sticky", {31'd0, coll_err}, 32'd1);
`endif

    // Mid-RUN reset erases the image (0x1F held 0x77)
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst2_core_hold",  {31'd0, core_hold},  32'd1);
    check("rst2_mar",        {27'd0, mar},        32'd0);
    check("rst2_prog_ready", {31'd0, prog_ready}, 32'd0);
`ifdef PATP_MS_COLLISION_CHECK_EN
    check("rst2_coll_err", {31'd0, coll_err}, 32'd0);
`endif
    wait_clear("clear2");
    prog_word(1'b0, 5'd0, 8'h00, 1'b1);
    check("run2_core_hold", {31'd0, core_hold}, 32'd0);
    cur_mar = 5'd0;
    read_addr(5'h1F, 8'h00);
    read_addr(5'h03, 8'h00);
    read_addr(5'h01, 8'h00);

    if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
